// File: rtl/rvv_xrf_writeback.sv
// rtl/rvv_xrf_writeback.sv - vector-to-scalar regfile writeback FIFO with pending scoreboard
// Arbitrates vector scalar-results against the scalar pipeline for the single regfile write port.
module rvv_xrf_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         async_rd_valid,
  input  logic [ADDR_W-1:0]            async_rd_addr,
  input  logic [DATA_W-1:0]            async_rd_data,
  output logic                         async_rd_ready,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_addr,
  input  logic                         scalar_wb_busy,
  output logic                         reg_write_valid,
  output logic [ADDR_W-1:0]            reg_write_addr,
  output logic [DATA_W-1:0]            reg_write_data,
  output logic [(1<<ADDR_W)-1:0]       pending,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         err_unexpected
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] X0       = '0;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [NREG-1:0]   pending_nxt;
  logic              push, pop, not_empty, head_is_x0;

  assign not_empty      = (fifo_count != '0);
  assign head_is_x0     = (mem_addr[rd_ptr] == X0);
  // Ready is gated by rst so the block refuses traffic while held in reset.
  assign async_rd_ready = !rst && (fifo_count < CNT_FULL);
  assign push           = async_rd_valid && async_rd_ready;
  // x0 results are discarded without waiting for the write port.
  assign pop             = not_empty && (head_is_x0 || !scalar_wb_busy);
  assign reg_write_valid = not_empty && !head_is_x0 && !scalar_wb_busy;
  assign reg_write_addr  = mem_addr[rd_ptr];
  assign reg_write_data  = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= async_rd_addr;
      mem_data[wr_ptr] <= async_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Clear first, then set, so a same-cycle reissue keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (reg_write_valid) pending_nxt[reg_write_addr] = 1'b0;
    if (issue_valid && issue_addr != X0) pending_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (push && async_rd_addr != X0 && !pending[async_rd_addr])
        err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rvv_xrf_writeback.sv
// tb/tb_rvv_xrf_writeback.sv - directed table and sequence bench for rvv_xrf_writeback
module tb_rvv_xrf_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        async_rd_valid;
  logic [4:0]  async_rd_addr;
  logic [31:0] async_rd_data;
  logic        async_rd_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        scalar_wb_busy;
  logic        reg_write_valid;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [31:0] pending;
  logic [2:0]  fifo_count;
  logic        err_unexpected;

  int checks = 0;
  int errors = 0;
  int wv_in_rst = 0;

  always #5 clk = ~clk;

  rvv_xrf_writeback #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .async_rd_valid(async_rd_valid), .async_rd_addr(async_rd_addr),
    .async_rd_data(async_rd_data), .async_rd_ready(async_rd_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .scalar_wb_busy(scalar_wb_busy),
    .reg_write_valid(reg_write_valid), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .pending(pending),
    .fifo_count(fifo_count), .err_unexpected(err_unexpected)
  );

  always @(negedge clk) if (rst && reg_write_valid) wv_in_rst++;

  typedef struct {
    logic        iv;
    logic [4:0]  ia;
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        busy;
    logic        e_ready;
    logic        e_wv;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [2:0]  e_count;
    logic [31:0] e_pend;
    logic        e_err;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic iv, logic [4:0] ia, logic v, logic [4:0] a, logic [31:0] d,
                              logic busy, logic e_ready, logic e_wv, logic [4:0] e_waddr,
                              logic [31:0] e_wdata, logic [2:0] e_count, logic [31:0] e_pend,
                              logic e_err);
    vec_t r;
    r.iv = iv; r.ia = ia; r.v = v; r.a = a; r.d = d; r.busy = busy;
    r.e_ready = e_ready; r.e_wv = e_wv; r.e_waddr = e_waddr; r.e_wdata = e_wdata;
    r.e_count = e_count; r.e_pend = e_pend; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ia, input logic v, input logic [4:0] a,
                       input logic [31:0] d, input logic busy);
    issue_valid = iv; issue_addr = ia;
    async_rd_valid = v; async_rd_addr = a; async_rd_data = d;
    scalar_wb_busy = busy;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  logic [4:0]  qa [$];
  logic [31:0] qd [$];
  int sent;
  logic exp_wv, exp_rdy;

  initial begin
    // Issue x5, push, write-back one cycle later; then x1..x4 held behind busy.
    tbl[0]  = mk(1, 5, 0, 0, 0,            0, 1, 0, 0, 0,            0, 32'h0,  0);
    tbl[1]  = mk(0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 0,            0, 32'h20, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,            0, 1, 1, 5, 32'hDEADBEEF, 1, 32'h20, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,            0, 1, 0, 0, 0,            0, 32'h0,  0);
    tbl[4]  = mk(1, 1, 0, 0, 0,            1, 1, 0, 0, 0,            0, 32'h0,  0);
    tbl[5]  = mk(1, 2, 0, 0, 0,            1, 1, 0, 0, 0,            0, 32'h2,  0);
    tbl[6]  = mk(1, 3, 0, 0, 0,            1, 1, 0, 0, 0,            0, 32'h6,  0);
    tbl[7]  = mk(1, 4, 1, 1, 32'h11,       1, 1, 0, 0, 0,            0, 32'hE,  0);
    tbl[8]  = mk(0, 0, 1, 2, 32'h22,       1, 1, 0, 0, 0,            1, 32'h1E, 0);
    tbl[9]  = mk(0, 0, 1, 3, 32'h33,       1, 1, 0, 0, 0,            2, 32'h1E, 0);
    tbl[10] = mk(0, 0, 1, 4, 32'h44,       1, 1, 0, 0, 0,            3, 32'h1E, 0);
    tbl[11] = mk(0, 0, 0, 0, 0,            1, 0, 0, 0, 0,            4, 32'h1E, 0);
    tbl[12] = mk(0, 0, 0, 0, 0,            0, 0, 1, 1, 32'h11,       4, 32'h1E, 0);
    tbl[13] = mk(0, 0, 0, 0, 0,            0, 1, 1, 2, 32'h22,       3, 32'h1C, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,            0, 1, 1, 3, 32'h33,       2, 32'h18, 0);
    tbl[15] = mk(0, 0, 0, 0, 0,            0, 1, 1, 4, 32'h44,       1, 32'h10, 0);
    tbl[16] = mk(0, 0, 0, 0, 0,            0, 1, 0, 0, 0,            0, 32'h0,  0);

    rst = 1'b1;
    idle();
    #2;
    chk("rst_ready", async_rd_ready, 0);
    chk("rst_wv", reg_write_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err_unexpected, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_ready", async_rd_ready, 1);

    step();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].ia, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].busy);
      #4;
      chk($sformatf("tbl%0d_ready", i), async_rd_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_wv", i), reg_write_valid, tbl[i].e_wv);
      if (tbl[i].e_wv) begin
        chk($sformatf("tbl%0d_waddr", i), reg_write_addr, tbl[i].e_waddr);
        chk($sformatf("tbl%0d_wdata", i), reg_write_data, tbl[i].e_wdata);
      end
      chk($sformatf("tbl%0d_count", i), fifo_count, tbl[i].e_count);
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
      chk($sformatf("tbl%0d_err", i), err_unexpected, tbl[i].e_err);
      step();
    end

    // Streaming across pointer wrap: fill to full, then push alongside pops.
    for (int r = 10; r < 20; r++) begin
      drive(1'b1, 5'(r), 1'b0, 5'd0, 32'h0, 1'b0);
      step();
    end
    idle();
    #1 chk("stream_pending_set", pending, 32'h000FFC00);
    sent = 0;
    for (int cyc = 0; cyc < 40 && (sent < 10 || qa.size() > 0); cyc++) begin
      drive(1'b0, 5'd0, sent < 10, 5'(10 + sent), 32'h1000 + sent, cyc < 5);
      #4;
      exp_rdy = (qa.size() < 4);
      exp_wv  = (qa.size() > 0) && !scalar_wb_busy;
      chk($sformatf("stream%0d_ready", cyc), async_rd_ready, exp_rdy);
      chk($sformatf("stream%0d_count", cyc), fifo_count, qa.size());
      chk($sformatf("stream%0d_wv", cyc), reg_write_valid, exp_wv);
      if (cyc >= 6 && sent < 10) chk($sformatf("stream%0d_steady", cyc), fifo_count, 3);
      if (exp_wv) begin
        chk($sformatf("stream%0d_waddr", cyc), reg_write_addr, qa[0]);
        chk($sformatf("stream%0d_wdata", cyc), reg_write_data, qd[0]);
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (async_rd_valid && exp_rdy) begin
        qa.push_back(5'(10 + sent));
        qd.push_back(32'h1000 + sent);
        sent++;
      end
      step();
    end
    chk("stream_drained", (sent == 10 && qa.size() == 0) ? 1 : 0, 1);
    idle();
    #1;
    chk("stream_pending_clear", pending, 0);
    chk("stream_err", err_unexpected, 0);

    // Reissue collides with pop of x7; unissued x9 raises sticky error.
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0); step();
    drive(1'b0, 5'd0, 1'b1, 5'd7, 32'h77, 1'b0); step();
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("x7_wv", reg_write_valid, 1);
    chk("x7_waddr", reg_write_addr, 7);
    step();
    chk("x7_pending_kept", pending[7], 1);
    chk("x9_err_before", err_unexpected, 0);
    drive(1'b0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b0); step();
    idle();
    #1;
    chk("x9_err_set", err_unexpected, 1);
    chk("x9_wv_addr", reg_write_addr, 9);
    step();
    drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0); step();
    drive(1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0); step();
    idle(); step();
    chk("err_sticky", err_unexpected, 1);
    chk("after_traffic_count", fifo_count, 0);

    // x0 result is dropped even with the write port busy.
    drive(1'b0, 5'd0, 1'b1, 5'd0, 32'hAA, 1'b1); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("x0_count", fifo_count, 1);
    chk("x0_wv", reg_write_valid, 0);
    step();
    chk("x0_popped", fifo_count, 0);

    // Reset with three queued entries.
    for (int r = 1; r < 4; r++) begin
      drive(1'b1, 5'(r), 1'b0, 5'd0, 32'h0, 1'b1); step();
    end
    for (int r = 1; r < 4; r++) begin
      drive(1'b0, 5'd0, 1'b1, 5'(r), 32'h500 + r, 1'b1); step();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("prerst_count", fifo_count, 3);
    chk("prerst_pending", pending, 32'h0000008E);
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_count", fifo_count, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_ready", async_rd_ready, 0);
    chk("midrst_wv", reg_write_valid, 0);
    chk("midrst_err", err_unexpected, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_no_write", wv_in_rst, 0);
    chk("after_rst_ready", async_rd_ready, 1);
    chk("after_rst_count", fifo_count, 0);
    step();
    chk("after_rst_wv", reg_write_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvv_xrf_writeback.md
RVV_XRF_WRITEBACK -- requirements
Module: rvv_xrf_writeback

Interface
REQ-001 Parameter DEPTH, default 4: writeback FIFO entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 5: scalar register index width.
REQ-003 Parameter DATA_W, default 32: scalar register data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 async_rd_valid  in  1  vector core offers a scalar-result writeback.
REQ-007 async_rd_addr  in  ADDR_W  destination scalar register of the offered writeback.
REQ-008 async_rd_data  in  DATA_W  result data of the offered writeback.
REQ-009 async_rd_ready  out  1  block accepts the offered writeback this cycle.
REQ-010 issue_valid  in  1  a vector instruction with a scalar destination was dispatched this cycle.
REQ-011 issue_addr  in  ADDR_W  scalar destination of that dispatched instruction.
REQ-012 scalar_wb_busy  in  1  scalar pipeline owns the regfile write port this cycle.
REQ-013 reg_write_valid  out  1  regfile write strobe.
REQ-014 reg_write_addr  out  ADDR_W  regfile write index.
REQ-015 reg_write_data  out  DATA_W  regfile write data.
REQ-016 pending  out  2^ADDR_W  scoreboard; bit r set while a vector result for register r is outstanding.
REQ-017 fifo_count  out  clog2(DEPTH+1)  current FIFO occupancy.
REQ-018 err_unexpected  out  1  sticky flag: a writeback arrived for a register that was not pending.

Function
REQ-019 The block SHALL accept a writeback (push) in any cycle where async_rd_valid and async_rd_ready are both 1.
REQ-020 async_rd_ready SHALL be 1 exactly when fifo_count < DEPTH; it depends only on registered state, never on async_rd_valid or scalar_wb_busy.
REQ-021 FIFO SHALL preserve acceptance order; read/write pointers wrap modulo DEPTH.
REQ-022 There SHALL be no bypass path: an entry pushed at edge t is visible at the head and is eligible to write from cycle t+1 onward.
REQ-023 With fifo_count > 0 and a nonzero head address, reg_write_valid SHALL be 1 when scalar_wb_busy = 0; the head entry is popped in that same cycle.
REQ-024 With scalar_wb_busy = 1, reg_write_valid SHALL be 0 and the head entry SHALL be held unchanged.
REQ-025 With head address 0, the entry SHALL be popped in one cycle regardless of scalar_wb_busy, with reg_write_valid = 0.
REQ-026 reg_write_addr and reg_write_data SHALL reflect the head entry whenever fifo_count > 0; they are don't-care when empty.
REQ-027 A simultaneous push and pop SHALL leave fifo_count unchanged; push when full is impossible because ready = 0.
REQ-028 issue_valid with nonzero issue_addr SHALL set pending[issue_addr] at the next edge; an issue to x0 SHALL be ignored.
REQ-029 A pop with reg_write_valid = 1 SHALL clear pending[reg_write_addr] at the same edge.
REQ-030 If a set and a clear target the same bit in one cycle, the set SHALL win.
REQ-031 On push with nonzero async_rd_addr and pending[async_rd_addr] = 0, err_unexpected SHALL be set; it stays set until reset.
REQ-032 pending SHALL be a registered output with no combinational path from any input.

Reset
REQ-033 While rst = 1: pointers, fifo_count, pending, and err_unexpected SHALL be 0; reg_write_valid = 0; async_rd_ready = 0.
REQ-034 Assertion of rst mid-operation SHALL immediately discard all FIFO contents and scoreboard state, with no regfile write.
REQ-035 In the first cycle after rst deasserts, async_rd_ready SHALL be 1.

Verification
REQ-036 Issue x5; push {x5, 0xDEADBEEF} with busy = 0 -> reg_write_valid one cycle later with addr 5, data 0xDEADBEEF; pending[5] clears on that edge.
REQ-037 Hold busy = 1; push 4 entries for x1..x4 -> async_rd_ready = 0 at fifo_count = 4; release busy -> writes x1, x2, x3, x4 on 4 consecutive cycles; ready = 1 after the first pop.
REQ-038 FIFO full with busy = 0, and a valid push in the same cycle as a pop -> fifo_count stays at DEPTH-1 steady state; 10 back-to-back entries drain in order across pointer wrap.
REQ-039 Pop of x7 in the same cycle as a reissue to x7 -> pending[7] = 1 afterwards; a push for unissued x9 -> err_unexpected = 1, held through later traffic.
REQ-040 Push for x0 with busy = 1 -> popped next cycle, reg_write_valid stays 0; assert rst with 3 entries queued -> fifo_count = 0, pending = 0 immediately, no regfile writes.
